// File: rtl/traffic_pkg.sv
// Shared definitions for the 3-road traffic light bus: light codes, fault codes,
// monitor states and the decoded colour type used by controller and monitor.
package traffic_pkg;

    localparam logic [3:0] R1_RED    = 4'd0;
    localparam logic [3:0] R1_YELLOW = 4'd1;
    localparam logic [3:0] R1_GREEN  = 4'd2;
    localparam logic [3:0] R2_RED    = 4'd3;
    localparam logic [3:0] R2_YELLOW = 4'd4;
    localparam logic [3:0] R2_GREEN  = 4'd5;
    localparam logic [3:0] R3_RED    = 4'd6;
    localparam logic [3:0] R3_YELLOW = 4'd7;
    localparam logic [3:0] R3_GREEN  = 4'd8;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_ILLEGAL    = 3'd1;
    localparam logic [2:0] FC_CONFLICT   = 3'd2;
    localparam logic [2:0] FC_NO_YELLOW  = 3'd3;
    localparam logic [2:0] FC_YEL_LEN    = 3'd4;
    localparam logic [2:0] FC_YEL_ABORT  = 3'd5;
    localparam logic [2:0] FC_GREEN_LONG = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        RED     = 2'd1,
        YELLOW  = 2'd2,
        GREEN   = 2'd3
    } colour_e;

    // Codes outside a road's own three-value set decode to UNKNOWN.
    function automatic colour_e decode_colour(input logic [3:0] code,
                                              input logic [3:0] r_code,
                                              input logic [3:0] y_code,
                                              input logic [3:0] g_code);
        colour_e col;
        if (code == r_code) begin
            col = RED;
        end else if (code == y_code) begin
            col = YELLOW;
        end else if (code == g_code) begin
            col = GREEN;
        end else begin
            col = UNKNOWN;
        end
        return col;
    endfunction

    // Road number (1..3) of the lowest set bit, 0 when nothing is set.
    function automatic logic [1:0] lowest_road(input logic [2:0] hit);
        logic [1:0] road;
        if (hit[0]) begin
            road = 2'd1;
        end else if (hit[1]) begin
            road = 2'd2;
        end else if (hit[2]) begin
            road = 2'd3;
        end else begin
            road = 2'd0;
        end
        return road;
    endfunction

endpackage

// File: rtl/road_phase_checker.sv
// Per-road phase checker: decodes one road's light code, tracks the previous
// colour and consecutive yellow/green run lengths, and flags illegal sequences.
module road_phase_checker
    import traffic_pkg::*;
#(
    parameter logic [3:0] R_CODE      = R1_RED,
    parameter logic [3:0] Y_CODE      = R1_YELLOW,
    parameter logic [3:0] G_CODE      = R1_GREEN,
    parameter int         YELLOW_TIME = 2,
    parameter int         GREEN_MAX   = 7,
    parameter int         CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light,
    input  logic       upd_en,
    input  logic       clr,
    output logic       is_green,
    output logic       illegal,
    output logic       no_yel,
    output logic       yel_len,
    output logic       yel_abort,
    output logic       green_long
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    colour_e          cur_s;
    colour_e          prev_r;
    logic [CNT_W-1:0] yel_cnt_r;
    logic [CNT_W-1:0] grn_cnt_r;
    logic [CNT_W-1:0] yel_inc_s;
    logic [CNT_W-1:0] grn_inc_s;

    assign cur_s     = decode_colour(light, R_CODE, Y_CODE, G_CODE);
    assign yel_inc_s = (yel_cnt_r == CNT_MAX) ? yel_cnt_r : yel_cnt_r + CNT_W'(1);
    assign grn_inc_s = (grn_cnt_r == CNT_MAX) ? grn_cnt_r : grn_cnt_r + CNT_W'(1);

    // Sequence checks on the current sample against the registered history.
    always_comb begin
        is_green   = 1'b0;
        illegal    = 1'b0;
        no_yel     = 1'b0;
        yel_len    = 1'b0;
        yel_abort  = 1'b0;
        green_long = 1'b0;
        if (cur_s == UNKNOWN) begin
            illegal = 1'b1;
        end else if (cur_s == GREEN) begin
            is_green   = 1'b1;
            no_yel     = (prev_r == RED);
            yel_len    = (prev_r == YELLOW) && (yel_cnt_r != CNT_W'(YELLOW_TIME));
            green_long = (grn_inc_s > CNT_W'(GREEN_MAX));
        end else if (cur_s == YELLOW) begin
            yel_abort = (prev_r == GREEN);
        end else begin
            yel_abort = (prev_r == YELLOW);
        end
    end

    // History registers: frozen unless enabled, forgotten on a fault clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r    <= UNKNOWN;
            yel_cnt_r <= CNT_ZERO;
            grn_cnt_r <= CNT_ZERO;
        end else if (clr) begin
            prev_r    <= UNKNOWN;
            yel_cnt_r <= CNT_ZERO;
            grn_cnt_r <= CNT_ZERO;
        end else if (upd_en) begin
            prev_r    <= cur_s;
            yel_cnt_r <= (cur_s == YELLOW) ? yel_inc_s : CNT_ZERO;
            grn_cnt_r <= (cur_s == GREEN)  ? grn_inc_s : CNT_ZERO;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Receive-side checker for the 3-road traffic light bus: latches the first
// sequencing violation and requests all-road flashing until software clears it.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int YELLOW_TIME = 2,
    parameter int GREEN_MAX   = 7,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light1,
    input  logic [3:0] light2,
    input  logic [3:0] light3,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_road,
    output logic       flash
);

    localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);
    localparam logic [FL_W-1:0] FL_ZERO = {FL_W{1'b0}};

    mon_state_e      state_r;
    mon_state_e      state_nxt_s;
    logic            upd_en_s;
    logic            clr_s;
    logic            run_s;
    logic [2:0]      green_s;
    logic [2:0]      illegal_s;
    logic [2:0]      no_yel_s;
    logic [2:0]      yel_len_s;
    logic [2:0]      yel_abort_s;
    logic [2:0]      green_long_s;
    logic            conflict_s;
    logic [2:0]      viol_code_s;
    logic [1:0]      viol_road_s;
    logic            fault_r;
    logic [2:0]      fault_code_r;
    logic [1:0]      fault_road_r;
    logic            flash_r;
    logic [FL_W-1:0] flash_cnt_r;

    assign run_s    = (state_r == ST_RUN);
    assign upd_en_s = (state_r != ST_FAULT);
    assign clr_s    = (state_r == ST_FAULT) && fault_clr;

    road_phase_checker #(
        .R_CODE(R1_RED), .Y_CODE(R1_YELLOW), .G_CODE(R1_GREEN),
        .YELLOW_TIME(YELLOW_TIME), .GREEN_MAX(GREEN_MAX), .CNT_W(CNT_W)
    ) u_road1 (
        .clk(clk), .rst(rst), .light(light1), .upd_en(upd_en_s), .clr(clr_s),
        .is_green(green_s[0]), .illegal(illegal_s[0]), .no_yel(no_yel_s[0]),
        .yel_len(yel_len_s[0]), .yel_abort(yel_abort_s[0]), .green_long(green_long_s[0])
    );

    road_phase_checker #(
        .R_CODE(R2_RED), .Y_CODE(R2_YELLOW), .G_CODE(R2_GREEN),
        .YELLOW_TIME(YELLOW_TIME), .GREEN_MAX(GREEN_MAX), .CNT_W(CNT_W)
    ) u_road2 (
        .clk(clk), .rst(rst), .light(light2), .upd_en(upd_en_s), .clr(clr_s),
        .is_green(green_s[1]), .illegal(illegal_s[1]), .no_yel(no_yel_s[1]),
        .yel_len(yel_len_s[1]), .yel_abort(yel_abort_s[1]), .green_long(green_long_s[1])
    );

    road_phase_checker #(
        .R_CODE(R3_RED), .Y_CODE(R3_YELLOW), .G_CODE(R3_GREEN),
        .YELLOW_TIME(YELLOW_TIME), .GREEN_MAX(GREEN_MAX), .CNT_W(CNT_W)
    ) u_road3 (
        .clk(clk), .rst(rst), .light(light3), .upd_en(upd_en_s), .clr(clr_s),
        .is_green(green_s[2]), .illegal(illegal_s[2]), .no_yel(no_yel_s[2]),
        .yel_len(yel_len_s[2]), .yel_abort(yel_abort_s[2]), .green_long(green_long_s[2])
    );

    assign conflict_s = (green_s[0] & green_s[1]) | (green_s[0] & green_s[2]) |
                        (green_s[1] & green_s[2]);

    // Priority encoder: lowest code first, then lowest road; IDLE sees only the first two.
    always_comb begin
        viol_code_s = FC_NONE;
        viol_road_s = 2'd0;
        if (|illegal_s) begin
            viol_code_s = FC_ILLEGAL;
            viol_road_s = lowest_road(illegal_s);
        end else if (conflict_s) begin
            viol_code_s = FC_CONFLICT;
            viol_road_s = lowest_road(green_s);
        end else if (run_s && (|no_yel_s)) begin
            viol_code_s = FC_NO_YELLOW;
            viol_road_s = lowest_road(no_yel_s);
        end else if (run_s && (|yel_len_s)) begin
            viol_code_s = FC_YEL_LEN;
            viol_road_s = lowest_road(yel_len_s);
        end else if (run_s && (|yel_abort_s)) begin
            viol_code_s = FC_YEL_ABORT;
            viol_road_s = lowest_road(yel_abort_s);
        end else if (run_s && (|green_long_s)) begin
            viol_code_s = FC_GREEN_LONG;
            viol_road_s = lowest_road(green_long_s);
        end else begin
            viol_code_s = FC_NONE;
            viol_road_s = 2'd0;
        end
    end

    // Next-state logic for the IDLE / RUN / FAULT monitor.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (viol_code_s != FC_NONE) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (viol_code_s != FC_NONE) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fault latch: only the first violation is captured; a clear empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
            fault_road_r <= 2'd0;
        end else if (clr_s) begin
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
            fault_road_r <= 2'd0;
        end else if ((state_r != ST_FAULT) && (viol_code_s != FC_NONE)) begin
            fault_r      <= 1'b1;
            fault_code_r <= viol_code_s;
            fault_road_r <= viol_road_s;
        end
    end

    // Flash timer: restarts on FAULT entry, toggles every FLASH_HALF clocks inside FAULT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_r     <= 1'b0;
            flash_cnt_r <= FL_ZERO;
        end else if ((state_r != ST_FAULT) || fault_clr) begin
            flash_r     <= 1'b0;
            flash_cnt_r <= FL_ZERO;
        end else if (flash_cnt_r == FL_LAST) begin
            flash_r     <= ~flash_r;
            flash_cnt_r <= FL_ZERO;
        end else begin
            flash_cnt_r <= flash_cnt_r + FL_W'(1);
        end
    end

    assign fault      = fault_r;
    assign fault_code = fault_code_r;
    assign fault_road = fault_road_r;
    assign flash      = flash_r;

endmodule
